// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 1024x32 data memory between the L1 caches of two cores.
// One transaction in flight at a time; read data returns RD_LAT cycles after the read strobe.
module dmem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_rd_en,
    input  logic        c0_wr_en,
    input  logic [9:0]  c0_addr,
    input  logic [31:0] c0_wdata,
    input  logic        c1_rd_en,
    input  logic        c1_wr_en,
    input  logic [9:0]  c1_addr,
    input  logic [31:0] c1_wdata,
    output logic        c0_ack,
    output logic [31:0] c0_rdata,
    output logic        c1_ack,
    output logic [31:0] c1_rdata,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_t      state_reg, state_next;
    logic        rr_ptr_reg, rr_ptr_next;
    logic        grant_id_reg, grant_id_next;
    logic        busy_reg, busy_next;
    logic        op_wr_reg, op_wr_next;
    logic        mem_rd_en_reg, mem_rd_en_next;
    logic        mem_wr_en_reg, mem_wr_en_next;
    logic [9:0]  mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [1:0]  ack_reg, ack_next;
    logic [1:0]  rdata_load;
    logic [31:0] rdata_reg [2];

    logic [1:0]  rd_req;
    logic [1:0]  wr_req;
    logic [1:0]  req;
    logic [9:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        win;

    assign rd_req       = {c1_rd_en, c0_rd_en};
    assign wr_req       = {c1_wr_en, c0_wr_en};
    assign req          = rd_req | wr_req;
    assign req_addr[0]  = c0_addr;
    assign req_addr[1]  = c1_addr;
    assign req_wdata[0] = c0_wdata;
    assign req_wdata[1] = c1_wdata;

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_id_next  = grant_id_reg;
        op_wr_next     = op_wr_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        cnt_next       = cnt_reg;
        mem_rd_en_next = 1'b0;
        mem_wr_en_next = 1'b0;
        ack_next       = 2'b00;
        rdata_load     = 2'b00;
        win            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    // Contention goes to the pointer; a lone requester always wins.
                    win            = (&req) ? rr_ptr_reg : req[1];
                    grant_id_next  = win;
                    rr_ptr_next    = ~win;
                    op_wr_next     = wr_req[win];
                    mem_addr_next  = req_addr[win];
                    mem_wdata_next = req_wdata[win];
                    mem_wr_en_next = wr_req[win];
                    mem_rd_en_next = ~wr_req[win];
                    state_next     = ACCESS;
                end
            end
            ACCESS: begin
                if (op_wr_reg) begin
                    ack_next[grant_id_reg] = 1'b1;
                    state_next             = RESP;
                end else begin
                    cnt_next   = LAT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd0) begin
                    rdata_load[grant_id_reg] = 1'b1;
                    ack_next[grant_id_reg]   = 1'b1;
                    state_next               = RESP;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 1'b0;
            grant_id_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            op_wr_reg     <= 1'b0;
            mem_rd_en_reg <= 1'b0;
            mem_wr_en_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cnt_reg       <= '0;
            ack_reg       <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                rdata_reg[i] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_id_reg  <= grant_id_next;
            busy_reg      <= busy_next;
            op_wr_reg     <= op_wr_next;
            mem_rd_en_reg <= mem_rd_en_next;
            mem_wr_en_reg <= mem_wr_en_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            cnt_reg       <= cnt_next;
            ack_reg       <= ack_next;
            // Read data persists until the same core's next read completes.
            for (int i = 0; i < 2; i++) begin
                if (rdata_load[i]) begin
                    rdata_reg[i] <= mem_rdata;
                end
            end
        end
    end

    assign c0_ack    = ack_reg[0];
    assign c1_ack    = ack_reg[1];
    assign c0_rdata  = rdata_reg[0];
    assign c1_rdata  = rdata_reg[1];
    assign mem_rd_en = mem_rd_en_reg;
    assign mem_wr_en = mem_wr_en_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;
    assign grant_id  = grant_id_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a fixed-latency memory model (RD_LAT = 2).
// Cycle numbering: inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_dmem_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        c0_rd_en, c0_wr_en, c1_rd_en, c1_wr_en;
    logic [9:0]  c0_addr, c1_addr;
    logic [31:0] c0_wdata, c1_wdata;
    logic        c0_ack, c1_ack;
    logic [31:0] c0_rdata, c1_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy, grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .c0_rd_en  (c0_rd_en),
        .c0_wr_en  (c0_wr_en),
        .c0_addr   (c0_addr),
        .c0_wdata  (c0_wdata),
        .c1_rd_en  (c1_rd_en),
        .c1_wr_en  (c1_wr_en),
        .c1_addr   (c1_addr),
        .c1_wdata  (c1_wdata),
        .c0_ack    (c0_ack),
        .c0_rdata  (c0_rdata),
        .c1_ack    (c1_ack),
        .c1_rdata  (c1_rdata),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    // Memory contents as a fixed function of address.
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return (a == 10'h3FF) ? 32'h12345678 : {16'hA5A5, 6'd0, a};
    endfunction

    // Data is valid only in the cycle RD_LAT after the strobe; otherwise a poison value.
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_rd_en ? mem_word(mem_addr) : 32'hBAD0BAD0;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0, acks1, grants, found;
        c0_rd_en = 0; c0_wr_en = 0; c1_rd_en = 0; c1_wr_en = 0;
        c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
        reset = 1'b0;
        tick();
        tick();
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_grant",    32'(grant_id),  32'd0);
        check("rst_strobes",  32'({mem_rd_en, mem_wr_en}), 32'd0);
        check("rst_acks",     32'({c0_ack, c1_ack}), 32'd0);
        check("rst_addr",     32'(mem_addr),  32'd0);
        check("rst_wdata",    mem_wdata,      32'd0);
        check("rst_c0_rdata", c0_rdata,       32'd0);
        check("rst_c1_rdata", c1_rdata,       32'd0);
        reset = 1'b1;
        tick();

        // Single write from core 0
        c0_wr_en = 1; c0_addr = 10'h155; c0_wdata = 32'hDEADBEEF;
        check("wr_c0_busy", 32'(busy), 32'd0);
        tick();
        check("wr_strobe",  32'(mem_wr_en), 32'd1);
        check("wr_nord",    32'(mem_rd_en), 32'd0);
        check("wr_addr",    32'(mem_addr),  32'h155);
        check("wr_wdata",   mem_wdata,      32'hDEADBEEF);
        check("wr_c1_busy", 32'(busy),      32'd1);
        check("wr_c1_ack",  32'(c0_ack),    32'd0);
        tick();
        check("wr_ack",     32'(c0_ack),    32'd1);
        check("wr_c1_idle", 32'(c1_ack),    32'd0);
        check("wr_strobe0", 32'(mem_wr_en), 32'd0);
        tick();
        c0_wr_en = 0;
        check("wr_ack_1cyc", 32'(c0_ack), 32'd0);
        tick();
        check("wr_no_regrant", 32'(busy), 32'd0);
        $display("txn single write core0 addr=155 done");

        // Single read from core 1, RD_LAT=2
        c1_rd_en = 1; c1_addr = 10'h3FF;
        tick();
        check("rd_strobe", 32'(mem_rd_en), 32'd1);
        check("rd_addr",   32'(mem_addr),  32'h3FF);
        check("rd_grant",  32'(grant_id),  32'd1);
        tick();
        check("rd_c2_ack", 32'(c1_ack), 32'd0);
        check("rd_c2_strobe", 32'(mem_rd_en), 32'd0);
        tick();
        check("rd_c3_ack", 32'(c1_ack), 32'd0);
        tick();
        check("rd_ack",   32'(c1_ack), 32'd1);
        check("rd_data",  c1_rdata,    32'h12345678);
        check("rd_c0ack", 32'(c0_ack), 32'd0);
        tick();
        c1_rd_en = 0;
        check("rd_hold",  c1_rdata, 32'h12345678);
        check("rd_c0_data", c0_rdata, 32'd0);
        $display("txn single read core1 addr=3FF data=%h", c1_rdata);

        // Simultaneous writes right after reset: core 0 first
        do_reset();
        c0_wr_en = 1; c0_addr = 10'h010; c0_wdata = 32'h11111111;
        c1_wr_en = 1; c1_addr = 10'h020; c1_wdata = 32'h22222222;
        tick();
        check("sim_c1_strobe", 32'(mem_wr_en), 32'd1);
        check("sim_c1_addr",   32'(mem_addr),  32'h010);
        check("sim_c1_grant",  32'(grant_id),  32'd0);
        tick();
        check("sim_c0_ack", 32'(c0_ack), 32'd1);
        check("sim_c1_ack_early", 32'(c1_ack), 32'd0);
        tick();
        c0_wr_en = 0;
        check("sim_c3_strobe", 32'(mem_wr_en), 32'd0);
        tick();
        check("sim_c4_strobe", 32'(mem_wr_en), 32'd1);
        check("sim_c4_addr",   32'(mem_addr),  32'h020);
        check("sim_c4_wdata",  mem_wdata,      32'h22222222);
        check("sim_c4_grant",  32'(grant_id),  32'd1);
        tick();
        check("sim_c1_ack", 32'(c1_ack), 32'd1);
        check("sim_c0_ack_again", 32'(c0_ack), 32'd0);
        tick();
        c1_wr_en = 0;
        $display("txn simultaneous writes core0 then core1 done");

        // Continuous contention, 8 transactions
        acks0 = 0; acks1 = 0; grants = 0;
        c0_wr_en = 1; c0_addr = 10'h100; c0_wdata = 32'hC0C0C0C0;
        c1_wr_en = 1; c1_addr = 10'h200; c1_wdata = 32'hC1C1C1C1;
        for (int cyc = 0; cyc < 60 && (acks0 + acks1) < 8; cyc++) begin
            tick();
            check("cont_one_strobe", 32'(mem_rd_en & mem_wr_en), 32'd0);
            check("cont_one_ack",    32'(c0_ack & c1_ack),       32'd0);
            if (mem_wr_en) begin
                check("cont_grant", 32'(grant_id), 32'(grants % 2));
                check("cont_addr",  32'(mem_addr), (grants % 2 == 1) ? 32'h200 : 32'h100);
                grants++;
            end
            if (c0_ack) acks0++;
            if (c1_ack) acks1++;
            if (acks0 + acks1 == 8) begin
                c0_wr_en = 0;
                c1_wr_en = 0;
            end
        end
        check("cont_acks0",  32'(acks0),  32'd4);
        check("cont_acks1",  32'(acks1),  32'd4);
        check("cont_grants", 32'(grants), 32'd8);
        tick();
        tick();
        check("cont_idle", 32'(busy), 32'd0);
        $display("txn contention acks0=%0d acks1=%0d", acks0, acks1);

        // Reset during WAIT of a core 0 read
        c0_rd_en = 1; c0_addr = 10'h02A;
        tick();
        check("rr_strobe", 32'(mem_rd_en), 32'd1);
        tick();
        check("rr_wait_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rr_busy",   32'(busy),     32'd0);
        check("rr_grant",  32'(grant_id), 32'd0);
        check("rr_addr",   32'(mem_addr), 32'd0);
        check("rr_strobes", 32'({mem_rd_en, mem_wr_en}), 32'd0);
        check("rr_c1_rdata", c1_rdata,    32'd0);
        tick();
        check("rr_no_ack", 32'(c0_ack), 32'd0);
        tick();
        check("rr_no_ack2", 32'(c0_ack), 32'd0);
        reset = 1'b1;
        found = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (mem_rd_en) begin
                found = i;
                break;
            end
        end
        check("rr_regrant_in_2", 32'(found >= 1 && found <= 2), 32'd1);
        check("rr_regrant_addr", 32'(mem_addr), 32'h02A);
        tick();
        tick();
        tick();
        check("rr_ack",  32'(c0_ack), 32'd1);
        check("rr_data", c0_rdata,    32'hA5A5002A);
        tick();
        c0_rd_en = 0;
        $display("txn reset mid-read core0 re-served data=%h", c0_rdata);

        // Dual enable is a write
        c0_rd_en = 1; c0_wr_en = 1; c0_addr = 10'h077; c0_wdata = 32'hCAFEF00D;
        tick();
        check("dual_wr", 32'(mem_wr_en), 32'd1);
        check("dual_rd", 32'(mem_rd_en), 32'd0);
        check("dual_wdata", mem_wdata,   32'hCAFEF00D);
        tick();
        check("dual_ack",   32'(c0_ack), 32'd1);
        check("dual_rdata", c0_rdata,    32'hA5A5002A);
        tick();
        c0_rd_en = 0; c0_wr_en = 0;
        $display("txn dual-enable write core0 addr=077 done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
